// File: rtl/func_pkg.sv
// func_pkg: shared FSM encodings, default multiplier width and saturation constant.
package func_pkg;
  localparam int MW_DEF = 24;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SQ = 3'd1;
  localparam logic [2:0] S_CU = 3'd2;
  localparam logic [2:0] S_SUB = 3'd3;
  localparam logic [2:0] S_SQR = 3'd4;
  localparam logic [15:0] SAT16 = 16'hFFFF;
endpackage

// File: rtl/func_inv_if.sv
// func_inv_if: start/busy request and result bundle for func_inv.
interface func_inv_if;
  logic start_i;
  logic [7:0] y_bi;
  logic [7:0] a_bi;
  logic busy_o;
  logic [15:0] y_bo;
  logic ovf_o;
  modport master(output start_i, y_bi, a_bi, input busy_o, y_bo, ovf_o);
  modport slave(input start_i, y_bi, a_bi, output busy_o, y_bo, ovf_o);
endinterface

// File: rtl/mul_seq.sv
// mul_seq: MW x MW -> 2MW shift-add multiplier, one bit of b per cycle, product held until next start.
module mul_seq #(
  parameter int MW = 24
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [MW-1:0]   a_bi,
  input  logic [MW-1:0]   b_bi,
  input  logic            start_i,
  output logic            busy_o,
  output logic [2*MW-1:0] y_bo
);
  localparam int CW = $clog2(MW);
  localparam logic W_IDLE = 1'b0;
  localparam logic W_WORK = 1'b1;
  logic            r_state;
  logic [CW-1:0]   r_cnt;
  logic [2*MW-1:0] r_a;
  logic [MW-1:0]   r_b;
  logic [2*MW-1:0] r_acc;
  logic [2*MW-1:0] r_p;
  logic [2*MW-1:0] w_sum;
  assign w_sum = r_acc + (r_b[0] ? r_a : '0);
  assign busy_o = r_state == W_WORK;
  assign y_bo = r_p;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= W_IDLE;
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_p <= '0;
    end else if (r_state == W_IDLE) begin
      if (start_i) begin
        r_state <= W_WORK;
        r_cnt <= '0;
        r_a <= {{MW{1'b0}}, a_bi};
        r_b <= b_bi;
        r_acc <= '0;
      end
    end else begin
      r_acc <= w_sum;
      r_a <= r_a << 1;
      r_b <= r_b >> 1;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(MW - 1)) begin
        r_state <= W_IDLE;
        r_p <= w_sum;
      end
    end
  end
endmodule

// File: rtl/func_inv.sv
// func_inv: sequential b = (y^3 - a)^2 with clamp at zero, 16-bit result plus overflow flag.
// Define FUNC_INV_SAT_EN to saturate y_bo to 0xFFFF on overflow instead of truncating.
module func_inv
  import func_pkg::*;
#(
  parameter int MW = MW_DEF
) (
  input logic     clk_i,
  input logic     rst_i,
  func_inv_if.slave bus
);
  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [7:0]      r_y;
  logic [7:0]      r_a;
  logic [15:0]     r_yo;
  logic            r_ovf;
  logic            w_mbusy;
  logic            w_mstart;
  logic [MW-1:0]   w_ma;
  logic [MW-1:0]   w_mb;
  logic [2*MW-1:0] w_p;
  logic [23:0]     w_cube;
  logic [MW-1:0]   w_d;
  logic            w_ovf;
  logic [15:0]     w_res;
  always_comb begin
    w_next = r_state == S_IDLE ? (bus.start_i ? S_SQ : S_IDLE) :
             r_state == S_SQ   ? (w_mbusy ? S_SQ : S_CU) :
             r_state == S_CU   ? (w_mbusy ? S_CU : S_SUB) :
             r_state == S_SUB  ? S_SQR :
             r_state == S_SQR  ? (w_mbusy ? S_SQR : S_IDLE) : S_IDLE;
  end
  assign w_cube = w_p[23:0];
  assign w_d = w_cube >= {16'b0, r_a} ? MW'(w_cube - {16'b0, r_a}) : '0;
  // The multiplier is kicked only on the edge entering a multiply phase.
  assign w_mstart = (w_next != r_state) && (w_next == S_SQ || w_next == S_CU || w_next == S_SQR);
  // Entering SQ the inputs are latched on the same edge, so square the live y.
  assign w_ma = w_next == S_SQ ? MW'(bus.y_bi) : w_next == S_CU ? w_p[MW-1:0] : w_d;
  assign w_mb = w_next == S_SQ ? MW'(bus.y_bi) : w_next == S_CU ? MW'(r_y) : w_d;
  assign w_ovf = |w_p[2*MW-1:16];
`ifdef FUNC_INV_SAT_EN
  assign w_res = w_ovf ? SAT16 : w_p[15:0];
`else
  assign w_res = w_p[15:0];
`endif
  mul_seq #(.MW(MW)) u_mul (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .a_bi   (w_ma),
    .b_bi   (w_mb),
    .start_i(w_mstart),
    .busy_o (w_mbusy),
    .y_bo   (w_p)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_y <= '0;
      r_a <= '0;
      r_yo <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.start_i) begin
        r_y <= bus.y_bi;
        r_a <= bus.a_bi;
      end
      if (r_state == S_SQR && w_next == S_IDLE) begin
        r_yo <= w_res;
        r_ovf <= w_ovf;
      end
    end
  end
  assign bus.busy_o = r_state != S_IDLE;
  assign bus.y_bo = r_yo;
  assign bus.ovf_o = r_ovf;
endmodule

// File: tb/tb_func_inv.sv
// tb_func_inv: randomized self-checking bench for func_inv against an arithmetic reference model.
module tb_func_inv;
  localparam int MW = 24;
  localparam int BUSY_CYC = 3 * MW + 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  func_inv_if bus();
  func_inv #(.MW(MW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic void ref_model(input logic [7:0] y, input logic [7:0] a,
                                    output logic [15:0] eb, output logic eo);
    longint c, d, b;
    c = longint'(y) * longint'(y) * longint'(y);
    d = c >= longint'(a) ? c - longint'(a) : 0;
    b = d * d;
    eo = b > 64'hFFFF;
`ifdef FUNC_INV_SAT_EN
    eb = eo ? 16'hFFFF : b[15:0];
`else
    eb = b[15:0];
`endif
  endfunction

  // Starts at a negedge, returns at the first negedge with busy_o low.
  task automatic run(input logic [7:0] y, input logic [7:0] a, output int cyc);
    bus.start_i = 1'b1;
    bus.y_bi = y;
    bus.a_bi = a;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.y_bi = 8'($urandom);
    bus.a_bi = 8'($urandom);
    cyc = 0;
    while (bus.busy_o === 1'b1 && cyc < 500) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string name, input logic [7:0] y, input logic [7:0] a);
    logic [15:0] eb;
    logic eo;
    ref_model(y, a, eb, eo);
    checks++;
    if (bus.y_bo !== eb) begin
      errors++;
      $display("FAIL %s y_bo: got %h expected %h", name, bus.y_bo, eb);
    end
    checks++;
    if (bus.ovf_o !== eo) begin
      errors++;
      $display("FAIL %s ovf_o: got %b expected %b", name, bus.ovf_o, eo);
    end
  endtask

  task automatic check_busy(input string name, input int cyc);
    checks++;
    if (cyc != BUSY_CYC) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d expected %0d", name, cyc, BUSY_CYC);
    end
  endtask

  task automatic test_reset();
    bus.start_i = 1'b1;
    bus.y_bi = 8'd5;
    bus.a_bi = 8'd1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.start_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.y_bo !== 16'h0 || bus.ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: got busy=%b y=%h ovf=%b expected 0/0000/0", bus.busy_o, bus.y_bo, bus.ovf_o);
    end
  endtask

  task automatic test_basic();
    int cyc;
    run(8'd3, 8'd7, cyc);
    check_busy("basic_3_7", cyc);
    check_result("basic_3_7", 8'd3, 8'd7);
    checks++;
    if (bus.y_bo !== 16'd400) begin
      errors++;
      $display("FAIL basic_3_7 literal: got %0d expected 400", bus.y_bo);
    end
    run(8'd2, 8'd10, cyc);
    check_busy("clamp_2_10", cyc);
    check_result("clamp_2_10", 8'd2, 8'd10);
  endtask

  task automatic test_back_to_back();
    int cyc;
    run(8'd6, 8'd200, cyc);
    check_busy("b2b_first", cyc);
    check_result("b2b_first", 8'd6, 8'd200);
    run(8'd1, 8'd0, cyc);
    check_busy("b2b_second", cyc);
    check_result("b2b_second", 8'd1, 8'd0);
  endtask

  task automatic test_overflow();
    int cyc;
    run(8'd40, 8'd0, cyc);
    check_busy("ovf_40_0", cyc);
    check_result("ovf_40_0", 8'd40, 8'd0);
  endtask

  task automatic test_ignore_start();
    int cyc;
    bus.start_i = 1'b1;
    bus.y_bi = 8'd9;
    bus.a_bi = 8'd100;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (MW + 9) @(negedge clk);
    bus.start_i = 1'b1;
    bus.y_bi = 8'd200;
    bus.a_bi = 8'd3;
    @(negedge clk);
    bus.start_i = 1'b0;
    cyc = 0;
    while (bus.busy_o === 1'b1 && cyc < 500) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc != BUSY_CYC - MW - 10) begin
      errors++;
      $display("FAIL ignore_start remaining busy: got %0d expected %0d", cyc, BUSY_CYC - MW - 10);
    end
    check_result("ignore_start", 8'd9, 8'd100);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start queued: got busy=%b expected 0", bus.busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bus.start_i = 1'b1;
    bus.y_bi = 8'd17;
    bus.a_bi = 8'd4;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (2 * MW + 9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.y_bo !== 16'h0 || bus.ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b y=%h ovf=%b expected 0/0000/0", bus.busy_o, bus.y_bo, bus.ovf_o);
    end
    run(8'd255, 8'd255, cyc);
    check_busy("after_reset", cyc);
    check_result("after_reset", 8'd255, 8'd255);
  endtask

  task automatic test_random();
    int cyc;
    logic [7:0] y, a;
    for (int i = 0; i < 10; i++) begin
      y = (i % 2 == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      a = 8'($urandom);
      run(y, a, cyc);
      check_busy("random", cyc);
      check_result("random", y, a);
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.y_bi = '0;
    bus.a_bi = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
